udp_sample_packetizer: RTL

UDP_SAMPLE_PACKETIZER -- requirements
Module: udp_sample_packetizer

---
 rtl/udp_sample_packetizer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/udp_sample_packetizer.sv
// udp_sample_packetizer
//   Wraps a raw 8-bit sample stream into UDP datagrams. Each datagram is a
//   UDP header (handed off on a valid/ready header channel) followed by a
//   payload of a 4-byte big-endian sequence number and PAYLOAD_LEN sample
//   bytes passed straight through from the input stream.
//
// Ports
//   clk, rst_n              clock, async active-low reset
//   enable                  allows a new datagram to start (sampled in IDLE only)
//   cfg_*                   addresses/ports, captured at datagram start
//   s_axis_*                raw sample byte stream in
//   m_udp_hdr_valid/ready   header handshake; m_udp_* header fields
//   m_udp_payload_axis_*    payload byte stream out
//   busy, seq_num, frame_done  status
module udp_sample_packetizer #(
    parameter int          PAYLOAD_LEN = 1024,
    parameter logic [7:0]  IP_TTL      = 8'd64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [31:0] cfg_source_ip,
    input  logic [31:0] cfg_dest_ip,
    input  logic [15:0] cfg_source_port,
    input  logic [15:0] cfg_dest_port,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic        m_udp_hdr_valid,
    input  logic        m_udp_hdr_ready,
    output logic [5:0]  m_udp_ip_dscp,
    output logic [1:0]  m_udp_ip_ecn,
    output logic [7:0]  m_udp_ip_ttl,
    output logic [31:0] m_udp_ip_source_ip,
    output logic [31:0] m_udp_ip_dest_ip,
    output logic [15:0] m_udp_source_port,
    output logic [15:0] m_udp_dest_port,
    output logic [15:0] m_udp_length,
    output logic [15:0] m_udp_checksum,
    output logic [7:0]  m_udp_payload_axis_tdata,
    output logic        m_udp_payload_axis_tvalid,
    input  logic        m_udp_payload_axis_tready,
    output logic        m_udp_payload_axis_tlast,
    output logic        m_udp_payload_axis_tuser,
    output logic        busy,
    output logic [31:0] seq_num,
    output logic        frame_done
);

    typedef enum logic [1:0] {IDLE, HDR, SEQ, DATA} state_t;

    // UDP length covers the 8-byte UDP header, the sequence word and samples
    localparam logic [15:0] UDP_LEN  = 16'(8 + 4 + PAYLOAD_LEN);
    localparam logic [15:0] LAST_CNT = 16'(PAYLOAD_LEN - 1);

    state_t      state_q, state_d;
    logic [31:0] seq_q, seq_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic        done_d;
    logic        latch_hdr;
    logic [7:0]  seq_byte;

    logic [31:0] src_ip_q, dst_ip_q;
    logic [15:0] src_port_q, dst_port_q;
    logic        hdr_loaded_q;

    always_comb begin
        case (idx_q)
            2'd0:    seq_byte = seq_q[31:24];
            2'd1:    seq_byte = seq_q[23:16];
            2'd2:    seq_byte = seq_q[15:8];
            default: seq_byte = seq_q[7:0];
        endcase
    end

    always_comb begin
        state_d   = state_q;
        seq_d     = seq_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        latch_hdr = 1'b0;

        m_udp_hdr_valid           = 1'b0;
        m_udp_payload_axis_tdata  = 8'h00;
        m_udp_payload_axis_tvalid = 1'b0;
        m_udp_payload_axis_tlast  = 1'b0;
        s_axis_tready             = 1'b0;

        case (state_q)
            IDLE: begin
                // start only once a sample is waiting; the byte stays in the source
                if (enable && s_axis_tvalid) begin
                    state_d   = HDR;
                    latch_hdr = 1'b1;
                end
            end
            HDR: begin
                m_udp_hdr_valid = 1'b1;
                if (m_udp_hdr_ready) state_d = SEQ;
            end
            SEQ: begin
                m_udp_payload_axis_tdata  = seq_byte;
                m_udp_payload_axis_tvalid = 1'b1;
                if (m_udp_payload_axis_tready) begin
                    if (idx_q == 2'd3) begin
                        idx_d   = 2'd0;
                        state_d = DATA;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            DATA: begin
                // zero-latency pass-through of the sample stream
                m_udp_payload_axis_tdata  = s_axis_tdata;
                m_udp_payload_axis_tvalid = s_axis_tvalid;
                s_axis_tready             = m_udp_payload_axis_tready;
                m_udp_payload_axis_tlast  = (cnt_q == LAST_CNT);
                if (s_axis_tvalid && m_udp_payload_axis_tready) begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = 16'd0;
                        seq_d   = seq_q + 32'd1;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            seq_q      <= 32'd0;
            cnt_q      <= 16'd0;
            idx_q      <= 2'd0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            seq_q      <= seq_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            frame_done <= done_d;
        end
    end

    // Header fields are frozen from datagram start until the next start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_ip_q     <= 32'd0;
            dst_ip_q     <= 32'd0;
            src_port_q   <= 16'd0;
            dst_port_q   <= 16'd0;
            hdr_loaded_q <= 1'b0;
        end else if (latch_hdr) begin
            src_ip_q     <= cfg_source_ip;
            dst_ip_q     <= cfg_dest_ip;
            src_port_q   <= cfg_source_port;
            dst_port_q   <= cfg_dest_port;
            hdr_loaded_q <= 1'b1;
        end
    end

    // constant fields read as zero until a header has been captured
    assign m_udp_ip_dscp      = 6'd0;
    assign m_udp_ip_ecn       = 2'd0;
    assign m_udp_ip_ttl       = hdr_loaded_q ? IP_TTL : 8'd0;
    assign m_udp_length       = hdr_loaded_q ? UDP_LEN : 16'd0;
    assign m_udp_checksum     = 16'h0000;
    assign m_udp_ip_source_ip = src_ip_q;
    assign m_udp_ip_dest_ip   = dst_ip_q;
    assign m_udp_source_port  = src_port_q;
    assign m_udp_dest_port    = dst_port_q;

    assign m_udp_payload_axis_tuser = 1'b0;
    assign busy    = (state_q != IDLE);
    assign seq_num = seq_q;

endmodule
